// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the SRAM responder.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slv_state_e;

    // Little-endian lane mask for a legal, aligned transfer.
    function automatic logic [3:0] byte_en(input logic [2:0] size,
                                           input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            HSIZE_BYTE: be = 4'b0001 << off;
            HSIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: be = 4'b1111;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// Word-organised SRAM: byte-enable synchronous write, asynchronous read.
module ahb_slv_mem #(
    parameter int DEPTH = 256,
    parameter int DATAW = 32,
    parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDXW-1:0]  waddr,
    input  logic [DATAW-1:0] wdata,
    input  logic [IDXW-1:0]  raddr,
    output logic [DATAW-1:0] rdata
);

    logic [DATAW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of an on-chip SRAM with programmable
// wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDRW       = 32,
    parameter int DATAW       = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsel,
    input  logic [ADDRW-1:0] haddr,
    input  logic [1:0]       htrans,
    input  logic             hwrite,
    input  logic [2:0]       hsize,
    input  logic [2:0]       hburst,
    input  logic [DATAW-1:0] hwdata,
    input  logic             hready,
    output logic             hreadyout,
    output logic             hresp,
    output logic [DATAW-1:0] hrdata
);

    localparam int IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDRW-1:0] DEPTH_L = ADDRW'(MEM_DEPTH);
    localparam logic [3:0] WS_L = 4'(WAIT_STATES);

    slv_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ADDRW-1:0] addr_q, addr_d;
    logic             write_q, write_d;
    logic [2:0]       size_q, size_d;
    logic             act_q, act_d;

    logic             accept;
    logic             misalign;
    logic             illegal;
    logic             final_ok;
    logic             mem_we;
    logic [3:0]       mem_be;
    logic [DATAW-1:0] mem_rdata;
    logic [IDXW-1:0]  mem_idx;
    logic             unused_bits;

    assign accept   = hsel && hready && htrans[1];
    assign misalign = ((hsize == HSIZE_HALF) && haddr[0])
                   || ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    assign illegal  = ({2'b00, haddr[ADDRW-1:2]} >= DEPTH_L)
                   || (hsize > 3'd2) || misalign;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        act_d     = act_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        unique case (1'b1)
            (state_q == ST_WAIT): begin
                hreadyout = 1'b0;
                if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            (state_q == ST_ERR1): begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: begin
                // IDLE and ERR2 both end a data phase and may take a new one.
                hresp   = (state_q == ST_ERR2);
                state_d = ST_IDLE;
                act_d   = 1'b0;
                if (accept) begin
                    addr_d  = haddr;
                    write_d = hwrite;
                    size_d  = hsize;
                    if (illegal) begin
                        state_d = ST_ERR1;
                    end else begin
                        act_d = 1'b1;
                        if (WS_L != 4'd0) begin
                            state_d = ST_WAIT;
                            cnt_d   = WS_L;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            act_q   <= act_d;
        end
    end

    assign final_ok = act_q && (state_q == ST_IDLE);
    assign mem_we   = final_ok && write_q;
    assign mem_be   = byte_en(size_q, addr_q[1:0]);
    assign mem_idx  = addr_q[IDXW+1:2];
    assign hrdata   = (final_ok && !write_q) ? mem_rdata : '0;

    assign unused_bits = ^{hburst, htrans[0], addr_q[ADDRW-1:IDXW+2]};

    ahb_slv_mem #(
        .DEPTH (MEM_DEPTH),
        .DATAW (DATAW),
        .IDXW  (IDXW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .be    (mem_be),
        .waddr (mem_idx),
        .wdata (hwdata),
        .raddr (mem_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance without and one with wait states,
// checked against a byte-level memory model.
module tb_ahb_sram_slave;

    logic        clk;
    logic        rst;
    logic        hsel      [2];
    logic [31:0] haddr     [2];
    logic [1:0]  htrans    [2];
    logic        hwrite    [2];
    logic [2:0]  hsize     [2];
    logic [2:0]  hburst    [2];
    logic [31:0] hwdata    [2];
    logic        hready    [2];
    logic        hreadyout [2];
    logic        hresp     [2];
    logic [31:0] hrdata    [2];

    logic [31:0] mdl [2][256];
    int checks;
    int errors;

    assign hready[0] = hreadyout[0];
    assign hready[1] = hreadyout[1];

    ahb_sram_slave #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .hsel(hsel[0]), .haddr(haddr[0]),
        .htrans(htrans[0]), .hwrite(hwrite[0]), .hsize(hsize[0]),
        .hburst(hburst[0]), .hwdata(hwdata[0]), .hready(hready[0]),
        .hreadyout(hreadyout[0]), .hresp(hresp[0]), .hrdata(hrdata[0])
    );

    ahb_sram_slave #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .hsel(hsel[1]), .haddr(haddr[1]),
        .htrans(htrans[1]), .hwrite(hwrite[1]), .hsize(hsize[1]),
        .hburst(hburst[1]), .hwdata(hwdata[1]), .hready(hready[1]),
        .hreadyout(hreadyout[1]), .hresp(hresp[1]), .hrdata(hrdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
        int unsigned nb;
        if (sz > 3'd2) return 1'b0;
        nb = 32'd1 << sz;
        return ((a / 4) < 256) && ((a % nb) == 0);
    endfunction

    task automatic model_write(input int d, input logic [31:0] a,
                               input logic [2:0] sz, input logic [31:0] wd);
        int nb;
        int off;
        logic [7:0] idx;
        nb  = 1 << sz;
        off = int'(a[1:0]);
        idx = a[9:2];
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + nb) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    // Single non-pipelined transfer; reports what the data phase looked like.
    task automatic xfer(input int d, input logic [31:0] a, input logic w,
                        input logic [2:0] sz, input logic [31:0] wd,
                        output int lows, output logic r1, output logic rfin,
                        output logic [31:0] rd, output logic early_nz);
        hsel[d]   = 1'b1;
        haddr[d]  = a;
        htrans[d] = 2'b10;
        hwrite[d] = w;
        hsize[d]  = sz;
        hburst[d] = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        haddr[d]  = $urandom;
        hwrite[d] = 1'b0;
        hwdata[d] = wd;
        lows = 0; r1 = 1'b0; rfin = 1'b0; rd = '0; early_nz = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) r1 = hresp[d];
            if (hreadyout[d]) begin
                rfin = hresp[d];
                rd   = hrdata[d];
                break;
            end
            lows++;
            if (hrdata[d] != 32'd0) early_nz = 1'b1;
        end
        @(posedge clk); #1;
        hwdata[d] = '0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b0; haddr[d] = '0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
            hsize[d] = 3'd0; hburst[d] = 3'd0; hwdata[d] = '0;
        end
        #1 rst = 1'b0;
        #2;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({hreadyout[d], hresp[d], hrdata[d]} !== {1'b1, 1'b0, 32'd0}) begin
                errors++;
                $display("FAIL reset d%0d: got rdy=%b resp=%b rdata=%h want 1 0 0",
                         d, hreadyout[d], hresp[d], hrdata[d]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int lows;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b1; haddr[d] = 32'h10; htrans[d] = 2'b10;
            hwrite[d] = 1'b1; hsize[d] = 3'd2;
            @(posedge clk); #1;
            hwdata[d] = 32'hDEADBEEF;
            hwrite[d] = 1'b0;
            lows = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (hreadyout[d]) break;
                lows++;
            end
            checks++;
            if (lows !== ws(d)) begin
                errors++;
                $display("FAIL b2b_wr_lows d%0d: got %0d want %0d", d, lows, ws(d));
            end
            @(posedge clk); #1;
            model_write(d, 32'h10, 3'd2, 32'hDEADBEEF);
            hsel[d] = 1'b0; htrans[d] = 2'b00; hwdata[d] = '0;
            lows = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (hreadyout[d]) break;
                lows++;
            end
            checks++;
            if (lows !== ws(d) || hresp[d] !== 1'b0 || hrdata[d] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL b2b_rd d%0d: got lows=%0d resp=%b rdata=%h want %0d 0 deadbeef",
                         d, lows, hresp[d], hrdata[d], ws(d));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_byte_lanes;
        int lows; logic r1, rf, nz; logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            xfer(d, 32'h10, 1'b1, 3'd2, 32'h11223344, lows, r1, rf, rd, nz);
            model_write(d, 32'h10, 3'd2, 32'h11223344);
            xfer(d, 32'h13, 1'b1, 3'd0, 32'hAA000000, lows, r1, rf, rd, nz);
            model_write(d, 32'h13, 3'd0, 32'hAA000000);
            xfer(d, 32'h10, 1'b0, 3'd2, 32'h0, lows, r1, rf, rd, nz);
            checks++;
            if (rd !== 32'hAA223344) begin
                errors++;
                $display("FAIL byte_write d%0d: got %h want aa223344", d, rd);
            end
            xfer(d, 32'h10, 1'b1, 3'd1, 32'h00005566, lows, r1, rf, rd, nz);
            model_write(d, 32'h10, 3'd1, 32'h00005566);
            xfer(d, 32'h10, 1'b0, 3'd2, 32'h0, lows, r1, rf, rd, nz);
            checks++;
            if (rd !== 32'hAA225566) begin
                errors++;
                $display("FAIL half_write d%0d: got %h want aa225566", d, rd);
            end
        end
    endtask

    task automatic test_wait_states;
        int lows; logic r1, rf, nz; logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            xfer(d, 32'h20, 1'b1, 3'd2, 32'h600DCAFE, lows, r1, rf, rd, nz);
            model_write(d, 32'h20, 3'd2, 32'h600DCAFE);
            checks++;
            if (lows !== ws(d) || rf !== 1'b0) begin
                errors++;
                $display("FAIL wait_wr d%0d: got lows=%0d resp=%b want %0d 0", d, lows, rf, ws(d));
            end
            xfer(d, 32'h20, 1'b0, 3'd2, 32'h0, lows, r1, rf, rd, nz);
            checks++;
            if (lows !== ws(d) || nz !== 1'b0 || rd !== 32'h600DCAFE) begin
                errors++;
                $display("FAIL wait_rd d%0d: got lows=%0d early=%b rdata=%h want %0d 0 600dcafe",
                         d, lows, nz, rd, ws(d));
            end
        end
    endtask

    task automatic test_errors;
        int lows; logic r1, rf, nz; logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            xfer(d, 32'h0, 1'b1, 3'd2, 32'h0BADF00D, lows, r1, rf, rd, nz);
            model_write(d, 32'h0, 3'd2, 32'h0BADF00D);
            xfer(d, 32'h400, 1'b0, 3'd2, 32'h0, lows, r1, rf, rd, nz);
            checks++;
            if (lows !== 1 || r1 !== 1'b1 || rf !== 1'b1 || rd !== 32'd0) begin
                errors++;
                $display("FAIL err_range d%0d: got lows=%0d r1=%b r2=%b rdata=%h want 1 1 1 0",
                         d, lows, r1, rf, rd);
            end
            xfer(d, 32'h2, 1'b1, 3'd2, 32'hFFFFFFFF, lows, r1, rf, rd, nz);
            checks++;
            if (lows !== 1 || r1 !== 1'b1 || rf !== 1'b1) begin
                errors++;
                $display("FAIL err_align d%0d: got lows=%0d r1=%b r2=%b want 1 1 1",
                         d, lows, r1, rf);
            end
            xfer(d, 32'h0, 1'b0, 3'd2, 32'h0, lows, r1, rf, rd, nz);
            checks++;
            if (rd !== 32'h0BADF00D) begin
                errors++;
                $display("FAIL err_nowrite d%0d: got %h want 0badf00d", d, rd);
            end
        end
    endtask

    task automatic test_no_access;
        int lows; logic r1, rf, nz; logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 1'b1; haddr[d] = 32'h10; htrans[d] = 2'b01;
            hwrite[d] = 1'b1; hsize[d] = 3'd2;
            @(posedge clk); #1;
            hwdata[d] = 32'hFFFFFFFF;
            htrans[d] = 2'b00;
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                checks++;
                if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL idle_busy d%0d.%0d: got rdy=%b resp=%b want 1 0",
                             d, k, hreadyout[d], hresp[d]);
                end
                @(posedge clk); #1;
            end
            hsel[d] = 1'b0; htrans[d] = 2'b10;
            @(posedge clk); #1;
            htrans[d] = 2'b00; hwrite[d] = 1'b0;
            @(negedge clk);
            checks++;
            if (hreadyout[d] !== 1'b1 || hresp[d] !== 1'b0) begin
                errors++;
                $display("FAIL nosel d%0d: got rdy=%b resp=%b want 1 0", d, hreadyout[d], hresp[d]);
            end
            @(posedge clk); #1;
            hwdata[d] = '0;
            xfer(d, 32'h10, 1'b0, 3'd2, 32'h0, lows, r1, rf, rd, nz);
            checks++;
            if (rd !== mdl[d][4]) begin
                errors++;
                $display("FAIL noacc_mem d%0d: got %h want %h", d, rd, mdl[d][4]);
            end
        end
    endtask

    task automatic test_random;
        int lows; logic r1, rf, nz; logic [31:0] rd;
        logic [31:0] a, wd; logic [2:0] sz; logic w; bit ok; int k;
        logic [7:0] idx;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                wd = $urandom;
                a  = 32'(i * 4);
                xfer(d, a, 1'b1, 3'd2, wd, lows, r1, rf, rd, nz);
                model_write(d, a, 3'd2, wd);
            end
            for (int i = 0; i < 60; i++) begin
                k  = $urandom_range(0, 9);
                sz = (k == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                a  = 32'($urandom_range(0, 63));
                if (k == 1) a = 32'h400 | ($urandom & 32'h0000FFFF);
                w  = 1'($urandom_range(0, 1));
                wd = $urandom;
                ok = legal(a, sz);
                xfer(d, a, w, sz, wd, lows, r1, rf, rd, nz);
                checks++;
                if (rf !== !ok || lows !== (ok ? ws(d) : 1) || (!ok && r1 !== 1'b1)) begin
                    errors++;
                    $display("FAIL rand_resp d%0d #%0d a=%h sz=%0d: got resp=%b r1=%b lows=%0d want resp=%b lows=%0d",
                             d, i, a, sz, rf, r1, lows, !ok, ok ? ws(d) : 1);
                end
                if (ok && w) model_write(d, a, sz, wd);
                if (ok && !w) begin
                    idx = a[9:2];
                    checks++;
                    if (rd !== mdl[d][idx]) begin
                        errors++;
                        $display("FAIL rand_rd d%0d #%0d a=%h: got %h want %h",
                                 d, i, a, rd, mdl[d][idx]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        int lows; logic r1, rf, nz; logic [31:0] rd;
        xfer(1, 32'h30, 1'b1, 3'd2, 32'h12345678, lows, r1, rf, rd, nz);
        model_write(1, 32'h30, 3'd2, 32'h12345678);
        hsel[1] = 1'b1; haddr[1] = 32'h30; htrans[1] = 2'b10;
        hwrite[1] = 1'b1; hsize[1] = 3'd2;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwrite[1] = 1'b0;
        hwdata[1] = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (hreadyout[1] !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: got rdy=%b want 0", hreadyout[1]);
        end
        #1 rst = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({hreadyout[d], hresp[d], hrdata[d]} !== {1'b1, 1'b0, 32'd0}) begin
                errors++;
                $display("FAIL mid_reset d%0d: got rdy=%b resp=%b rdata=%h want 1 0 0",
                         d, hreadyout[d], hresp[d], hrdata[d]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        hwdata[1] = '0;
        @(posedge clk); #1;
        xfer(1, 32'h30, 1'b0, 3'd2, 32'h0, lows, r1, rf, rd, nz);
        checks++;
        if (rd !== 32'h12345678 || lows !== 3) begin
            errors++;
            $display("FAIL mid_dropped: got rdata=%h lows=%0d want 12345678 3", rd, lows);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_back_to_back;
        test_byte_lanes;
        test_wait_states;
        test_errors;
        test_no_access;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
